// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, default width and multiplier state encoding
package alu_pkg;

    localparam logic [2:0] CTRL_ADD = 3'b000;
    localparam logic [2:0] CTRL_SUB = 3'b001;
    localparam logic [2:0] CTRL_XOR = 3'b010;
    localparam logic [2:0] CTRL_SLT = 3'b011;
    localparam logic [2:0] CTRL_MUL = 3'b100;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one combinational radix-2 shift-add multiply iteration
//
// Ports:
//   acc_i / acc_o       2*WIDTH-bit partial product in / out
//   mcand_i / mcand_o   2*WIDTH-bit multiplicand magnitude, shifted left per step
//   mplier_i / mplier_o WIDTH-bit multiplier magnitude, shifted right per step
module mul_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0]   mplier_o
);

    always_comb begin
        acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
        mcand_o  = mcand_i << 1;
        mplier_o = mplier_i >> 1;
    end

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - multi-cycle signed WIDTHxWIDTH multiplier for the ALU MUL operation
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (A, B two's complement)
//   out_valid / out_ready result handshake
//   Out                   low WIDTH bits of the signed product
//   zero, overflow        Out == 0; product does not fit in WIDTH signed bits
//   OutHi                 upper WIDTH bits of the product (only with MUL_HI_EN)
//
// Optional feature macro: MUL_HI_EN
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MUL_HI_EN
    output logic [WIDTH-1:0] OutHi,
`endif
    output logic [WIDTH-1:0] Out,
    output logic             zero,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mul_state_e state_q, state_d;

    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_q;
    logic [WIDTH-1:0]   out_q;
    logic               zero_q, ovf_q;
`ifdef MUL_HI_EN
    logic [WIDTH-1:0]   out_hi_q;
`endif

    logic [2*WIDTH-1:0] acc_step, mcand_step;
    logic [WIDTH-1:0]   mplier_step;
    logic [WIDTH-1:0]   a_mag_d, b_mag_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     top_bits;
    logic               ovf_d;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (acc_step),
        .mcand_o  (mcand_step),
        .mplier_o (mplier_step)
    );

    // The most negative operand negates to itself, which read as unsigned is
    // exactly its magnitude, so no special case is needed.
    always_comb begin
        a_mag_d  = A[WIDTH-1] ? -A : A;
        b_mag_d  = B[WIDTH-1] ? -B : B;
        prod_d   = sign_q ? -acc_q : acc_q;
        // Result fits iff the top WIDTH+1 bits are a pure sign extension.
        top_bits = prod_d[2*WIDTH-1:WIDTH-1];
        ovf_d    = !((&top_bits) || !(|top_bits));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN:  if (cnt_q == LAST_ITER) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            out_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef MUL_HI_EN
            out_hi_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag_d};
                        mplier_q <= b_mag_d;
                        cnt_q    <= '0;
                        sign_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                    end
                end
                RUN: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_step;
                    mplier_q <= mplier_step;
                    cnt_q    <= cnt_q + 1'b1;
                end
                FIX: begin
                    out_q    <= prod_d[WIDTH-1:0];
                    zero_q   <= (prod_d[WIDTH-1:0] == '0);
                    ovf_q    <= ovf_d;
`ifdef MUL_HI_EN
                    out_hi_q <= prod_d[2*WIDTH-1:WIDTH];
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign Out      = out_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
`ifdef MUL_HI_EN
    assign OutHi    = out_hi_q;
`endif

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - scoreboard bench for alu_mul_seq
module tb_alu_mul_seq;

    localparam int W = 32;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A, B;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Out;
    logic          zero;
    logic          overflow;
`ifdef MUL_HI_EN
    logic [W-1:0]  OutHi;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    alu_mul_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MUL_HI_EN
        .OutHi     (OutHi),
`endif
        .Out       (Out),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint p;
        logic [63:0] pu;
        p     = longint'($signed(a)) * longint'($signed(b));
        pu    = p;
        e.lo  = pu[31:0];
        e.hi  = pu[63:32];
        e.z   = (pu[31:0] == 32'd0);
        e.ovf = (p != longint'($signed(pu[31:0])));
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("issue_ready", {63'd0, in_ready}, 64'd1);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(model(a, b));
    endtask

    // Waits for the result while scrambling A/B and pulsing in_valid, which must all be ignored.
    task automatic collect(input string tag, input int hold_cycles);
        int   n = 0;
        exp_t e;
        while (n < 100) begin
            @(posedge clk); #1; n++;
            if (out_valid) break;
            A = $urandom; B = $urandom; in_valid = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(W + 1));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_out"},  64'(Out),      64'(e.lo));
        check({tag, "_zero"}, 64'(zero),     64'(e.z));
        check({tag, "_ovf"},  64'(overflow), 64'(e.ovf));
`ifdef MUL_HI_EN
        check({tag, "_hi"},   64'(OutHi),    64'(e.hi));
`endif
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_out"},   64'(Out),       64'(e.lo));
            check({tag, "_hold_flags"}, {62'd0, zero, overflow}, {62'd0, e.z, e.ovf});
            check({tag, "_hold_hs"},    {62'd0, out_valid, in_ready}, 64'b10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_hs"},  {62'd0, out_valid, in_ready}, 64'b01);
        check({tag, "_post_out"}, 64'(Out), 64'(e.lo));
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hs",    {62'd0, out_valid, in_ready}, 64'b01);
        check("rst_out",   64'(Out), 64'd0);
        check("rst_flags", {62'd0, zero, overflow}, 64'd0);
        #2 reset_n = 1'b1;

        issue(32'd2, 32'd5);                 collect("mul_2x5", 0);
        issue(32'd6, -32'sd3);               collect("mul_6xm3", 0);
        issue(32'd200000, 32'd200000);       collect("mul_big", 5);
        issue(32'h8000_0000, 32'd1);         collect("mul_min_x1", 0);
        issue(32'h8000_0000, 32'hFFFF_FFFF); collect("mul_min_xm1", 0);
        issue(32'd0, 32'd12345);             collect("mul_zero", 0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF); collect("mul_m1xm1", 0);
        for (int k = 0; k < 4; k++) begin
            issue($urandom, $urandom);       collect("mul_rand", 0);
        end

        // Abort mid-RUN: reset must take effect without waiting for a clock edge.
        issue(32'd1234, 32'd5678);
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_hs",    {62'd0, out_valid, in_ready}, 64'b01);
        check("abort_out",   64'(Out), 64'd0);
        check("abort_flags", {62'd0, zero, overflow}, 64'd0);
        sb.delete();
        @(posedge clk);
        #2 reset_n = 1'b1;

        issue(32'd7, 32'd7);                 collect("mul_7x7", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
